// File: rtl/gigerx_fifo_rd_packer.sv
// Pops bytes from the gigabit RX FIFO (read-clock domain) and packs them little-endian
// into 32-bit words with byte enables, presented on a valid/ready interface.
module gigerx_fifo_rd_packer #(
  parameter int PTR   = 8,
  parameter int CNT_W = 16
) (
  input  logic             rdclk,
  input  logic             aclr,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_q,
  output logic             fifo_rdreq,
  input  logic             flush,
  output logic [31:0]      dout,
  output logic [3:0]       dout_be,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] word_cnt
);

  // PTR only documents the source FIFO geometry; usedw is not consumed here.
  if (PTR < 1) begin : g_ptr_unused
  end

  logic [2:0]  idx_reg;
  logic        rd_pend_reg;
  logic        flush_pend_reg;
  logic [31:0] asm_reg;

  logic [2:0]  count;
  logic        slot_free;
  logic        full_now;
  logic        flush_load;
  logic        load;
  logic [31:0] merged;
  logic [31:0] load_word;
  logic [3:0]  load_be;

  // count includes the byte still in flight from the FIFO, so it never exceeds 4.
  assign count      = idx_reg + {2'b00, rd_pend_reg};
  assign slot_free  = !dout_valid || dout_ready;
  assign fifo_rdreq = !aclr && !fifo_empty && !flush_pend_reg && ((count < 3'd4) || slot_free);

  assign full_now   = (count == 3'd4);
  assign flush_load = flush_pend_reg && !rd_pend_reg && (idx_reg != 3'd0) && slot_free;
  assign load       = (full_now && slot_free) || flush_load;

  // Per lane: overlay the in-flight byte, then zero lanes beyond the fill level.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8]    = (rd_pend_reg && (idx_reg == 3'(gi))) ? fifo_q
                                                                         : asm_reg[8*gi +: 8];
      assign load_be[gi]          = (count > 3'(gi));
      assign load_word[8*gi +: 8] = load_be[gi] ? merged[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      idx_reg        <= 3'd0;
      rd_pend_reg    <= 1'b0;
      flush_pend_reg <= 1'b0;
      asm_reg        <= 32'h0;
      dout           <= 32'h0;
      dout_be        <= 4'h0;
      dout_valid     <= 1'b0;
      word_cnt       <= '0;
    end else begin
      rd_pend_reg <= fifo_rdreq;

      if (rd_pend_reg) begin
        asm_reg <= merged;
      end

      if (load) begin
        idx_reg <= 3'd0;
      end else if (rd_pend_reg) begin
        idx_reg <= idx_reg + 3'd1;
      end

      // A flush arriving while one is pending is dropped on purpose.
      if (flush_pend_reg) begin
        if (!rd_pend_reg && ((idx_reg == 3'd0) || flush_load)) begin
          flush_pend_reg <= 1'b0;
        end
      end else if (flush) begin
        flush_pend_reg <= 1'b1;
      end

      if (load) begin
        dout       <= load_word;
        dout_be    <= load_be;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (dout_valid && dout_ready) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gigerx_fifo_rd_packer.sv
// Bench for gigerx_fifo_rd_packer: behavioural FIFO, byte-group reference model
// and a word scoreboard, driven by directed cases followed by random traffic.
module tb_gigerx_fifo_rd_packer;
  localparam int CNT_W = 16;

  logic             rdclk = 1'b0;
  logic             aclr;
  logic             fifo_empty;
  logic [7:0]       fifo_q;
  logic             fifo_rdreq;
  logic             flush;
  logic [31:0]      dout;
  logic [3:0]       dout_be;
  logic             dout_valid;
  logic             dout_ready;
  logic [CNT_W-1:0] word_cnt;

  always #5 rdclk = ~rdclk;

  gigerx_fifo_rd_packer #(.PTR(8), .CNT_W(CNT_W)) dut (
    .rdclk      (rdclk),
    .aclr       (aclr),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .flush      (flush),
    .dout       (dout),
    .dout_be    (dout_be),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .word_cnt   (word_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned src_q[$];   // bytes still inside the FIFO
  byte unsigned grp_q[$];   // bytes popped but not yet part of an expected word
  logic [35:0]  exp_q[$];   // expected {be, word} in output order
  int           exp_cnt = 0;
  int           pops    = 0;
  logic         stall_prev = 1'b0;
  logic [35:0]  stall_val  = '0;
  logic [7:0]   next_q;
  logic         pop_now;
  logic         last_rdreq;
  logic         last_valid;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Every four consecutive popped bytes form one word, first byte lowest.
  task automatic model_byte(input byte unsigned b);
    grp_q.push_back(b);
    if (grp_q.size() == 4) begin
      exp_q.push_back({4'hF, grp_q[3], grp_q[2], grp_q[1], grp_q[0]});
      grp_q.delete();
    end
  endtask

  // A flush closes the current group as a partial word, if any bytes are in it.
  task automatic model_flush();
    logic [31:0] w;
    logic [3:0]  be;
    w  = '0;
    be = '0;
    for (int i = 0; i < grp_q.size(); i++) begin
      w[8*i +: 8] = grp_q[i];
      be[i]       = 1'b1;
    end
    if (grp_q.size() > 0) exp_q.push_back({be, w});
    grp_q.delete();
  endtask

  // One clock cycle; entered and left at the falling edge.
  task automatic step(input logic gate, input logic rdy, input logic fl);
    logic [35:0] e;
    fifo_empty = gate || (src_q.size() == 0);
    dout_ready = rdy;
    flush      = fl;
    #1;
    last_rdreq = fifo_rdreq;
    last_valid = dout_valid;
    pop_now    = 1'b0;
    check_val("rdreq_when_empty", fifo_rdreq & fifo_empty, 0);
    if (fifo_rdreq && !fifo_empty) begin
      pop_now = 1'b1;
      next_q  = src_q.pop_front();
      pops++;
      model_byte(next_q);
    end
    if (fl) model_flush();
    check_val("word_cnt", word_cnt, exp_cnt[CNT_W-1:0]);
    if (stall_prev) check_val("stall_hold", {dout_valid, dout_be, dout}, {1'b1, stall_val});
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check_val("valid_with_nothing_expected", dout_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("dout_be", dout_be, e[35:32]);
        check_val("dout", dout, e[31:0]);
      end
      exp_cnt++;
    end
    stall_prev = dout_valid && !dout_ready;
    stall_val  = {dout_be, dout};
    @(posedge rdclk);
    #1;
    fifo_q = pop_now ? next_q : 8'($urandom);
    @(negedge rdclk);
  endtask

  task automatic do_reset(input int ncyc);
    aclr       = 1'b1;
    fifo_empty = 1'b0;
    dout_ready = 1'b1;
    flush      = 1'b0;
    #1;
    check_val("rst_rdreq", fifo_rdreq, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_be", dout_be, 0);
    check_val("rst_valid", dout_valid, 0);
    check_val("rst_word_cnt", word_cnt, 0);
    repeat (ncyc) @(negedge rdclk);
    grp_q.delete();
    exp_q.delete();
    exp_cnt    = 0;
    stall_prev = 1'b0;
    aclr       = 1'b0;
  endtask

  initial begin
    int rd_first, rd_last, rd_n, pops0, cool;
    int v_list[$];
    logic [CNT_W-1:0] cnt0;
    logic fl, flushed;

    aclr       = 1'b1;
    fifo_q     = 8'h00;
    fifo_empty = 1'b0;
    dout_ready = 1'b0;
    flush      = 1'b0;
    @(negedge rdclk);
    do_reset(3);

    // Back-to-back stream of two words
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    rd_first = -1; rd_last = -1; rd_n = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 0) check_val("rdreq_after_reset", last_rdreq, 1);
      if (last_rdreq) begin
        if (rd_first < 0) rd_first = i;
        rd_last = i;
        rd_n++;
      end
      if (last_valid) v_list.push_back(i);
    end
    check_val("b2b_rdreq_count", rd_n, 8);
    check_val("b2b_rdreq_span", rd_last - rd_first + 1, 8);
    check_val("b2b_word_count", v_list.size(), 2);
    if (v_list.size() == 2) begin
      check_val("first_word_latency", v_list[0] - rd_first, 5);
      check_val("second_word_gap", v_list[1] - v_list[0], 4);
    end
    check_val("b2b_word_cnt", word_cnt, 2);

    // Backpressure: the slot holds one word, the assembly reg at most four more bytes
    cnt0  = word_cnt;
    pops0 = pops;
    for (int i = 1; i <= 12; i++) src_q.push_back(8'(i));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    check_val("bp_pop_count", pops - pops0, 8);
    check_val("bp_held_word", {dout_valid, dout}, {1'b1, 32'h04030201});
    step(1'b0, 1'b1, 1'b0);
    check_val("rdreq_on_ready_rise", last_rdreq, 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
    check_val("bp_word_cnt_delta", CNT_W'(word_cnt - cnt0), 3);
    check_val("bp_drained", exp_q.size() + grp_q.size(), 0);

    // Flush of a three-byte partial, then a flush with nothing buffered
    cnt0 = word_cnt;
    src_q.push_back(8'hAA); src_q.push_back(8'hBB); src_q.push_back(8'hCC);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    check_val("flush_word_cnt_delta", CNT_W'(word_cnt - cnt0), 1);
    check_val("flush_last_word", {dout_be, dout}, {4'b0111, 32'h00CCBBAA});
    cnt0 = word_cnt;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    check_val("empty_flush_word_cnt", word_cnt, cnt0);

    // FIFO empty flag toggling every cycle
    cnt0 = word_cnt;
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 24; i++) step(i % 2 == 0, 1'b1, 1'b0);
    check_val("toggle_word_cnt_delta", CNT_W'(word_cnt - cnt0), 2);
    check_val("toggle_drained", exp_q.size() + grp_q.size() + src_q.size(), 0);

    // Reset in the middle of a partial word
    src_q.push_back(8'h30); src_q.push_back(8'h31);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    do_reset(2);
    for (int i = 1; i <= 4; i++) src_q.push_back(8'(8'h20 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    check_val("post_reset_word_cnt", word_cnt, 1);
    check_val("post_reset_last_word", dout, 32'h24232221);

    // Random traffic: bursts, empty gating, backpressure and spaced flushes
    cool = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0 && src_q.size() < 40)
        repeat ($urandom_range(1, 6)) src_q.push_back(8'($urandom));
      fl = 1'b0;
      if (cool == 0 && $urandom_range(0, 19) == 0) begin
        fl   = 1'b1;
        cool = 3;
      end
      step($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, fl);
      if (!fl) begin
        if (exp_q.size() != 0) cool = 3;
        else if (cool > 0) cool--;
      end
    end

    // Drain everything, closing any trailing partial with one last flush
    flushed = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fl = 1'b0;
      if (!flushed && cool == 0 && src_q.size() == 0) begin
        fl      = 1'b1;
        flushed = 1'b1;
        cool    = 3;
      end
      step(1'b0, 1'b1, fl);
      if (!fl) begin
        if (exp_q.size() != 0) cool = 3;
        else if (cool > 0) cool--;
      end
      if (flushed && cool == 0) break;
    end
    check_val("final_drained", exp_q.size() + grp_q.size() + src_q.size(), 0);
    check_val("final_word_cnt", word_cnt, exp_cnt[CNT_W-1:0]);
    check_val("final_valid_low", dout_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
